// File: rtl/map_sel_ctrl_pkg.sv
// Shared definitions for the mapper-select controller: state encoding,
// default index width and a small constant helper.
package map_sel_ctrl_pkg;

  localparam int IDX_W_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESET  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/map_sel_ctrl_if.sv
// Request/status bundle between the configuration source and the
// mapper-select controller.
interface map_sel_ctrl_if
  import map_sel_ctrl_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF
);

  logic             req_stb;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] act_idx;
  logic             out_blank;
  logic             map_rst;
  logic             busy;
  logic             done;

  modport master (
    output req_stb, req_idx,
    input  act_idx, out_blank, map_rst, busy, done
  );

  modport slave (
    input  req_stb, req_idx,
    output act_idx, out_blank, map_rst, busy, done
  );

endinterface

// File: rtl/map_sel_ctrl_m2_sync_edge.sv
// Two-flop synchronizer for the console M2 clock plus a rising-edge
// detector on the synchronized level; shared with the bus-snooping mappers.
module m2_sync_edge
  import map_sel_ctrl_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_m2,
  output logic o_m2_s,
  output logic o_m2_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_m2;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_m2_s    = r_sync;
  assign o_m2_rise = r_sync & ~r_prev;

endmodule

// File: rtl/map_sel_ctrl.sv
// Runtime mapper switch sequencer: latches a requested index, waits for a
// safe M2 phase, blanks the hub, pulses mapper reset, then waits for M2 to settle.
module map_sel_ctrl
  import map_sel_ctrl_pkg::*;
#(
  parameter int IDX_W     = IDX_W_DEF,
  parameter int BOOT_IDX  = 0,
  parameter int RST_CYC   = 16,
  parameter int SETTLE_M2 = 2,
  parameter int TMO_CYC   = 4096
)(
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_m2,
  map_sel_ctrl_if.slave  bus
);

  localparam int CNT_W  = $clog2(maxInt(TMO_CYC, RST_CYC)) + 1;
  localparam int RISE_W = $clog2(SETTLE_M2 + 1);

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TMO_CYC - 1);
  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [RISE_W-1:0] M2_LAST  = RISE_W'(SETTLE_M2 - 1);

  logic w_m2S;
  logic w_m2Rise;

  m2_sync_edge u_m2Sync (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_m2      (i_m2),
    .o_m2_s    (w_m2S),
    .o_m2_rise (w_m2Rise)
  );

  state_t             r_state,     w_stateNxt;
  logic               r_pendValid, w_pendValidNxt;
  logic [IDX_W-1:0]   r_pendIdx,   w_pendIdxNxt;
  logic [IDX_W-1:0]   r_actIdx,    w_actIdxNxt;
  logic               r_blank,     w_blankNxt;
  logic               r_mapRst,    w_mapRstNxt;
  logic               r_busy,      w_busyNxt;
  logic               r_done,      w_doneNxt;
  logic [CNT_W-1:0]   r_cyc,       w_cycNxt;
  logic [RISE_W-1:0]  r_rise,      w_riseNxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_pendValid <= 1'b0;
      r_pendIdx   <= '0;
      r_actIdx    <= IDX_W'(BOOT_IDX);
      r_blank     <= 1'b0;
      r_mapRst    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cyc       <= '0;
      r_rise      <= '0;
    end else begin
      r_state     <= w_stateNxt;
      r_pendValid <= w_pendValidNxt;
      r_pendIdx   <= w_pendIdxNxt;
      r_actIdx    <= w_actIdxNxt;
      r_blank     <= w_blankNxt;
      r_mapRst    <= w_mapRstNxt;
      r_busy      <= w_busyNxt;
      r_done      <= w_doneNxt;
      r_cyc       <= w_cycNxt;
      r_rise      <= w_riseNxt;
    end
  end

  // The cycle counter restarts on every state entry and saturates otherwise.
  always_comb begin
    w_stateNxt     = r_state;
    w_pendValidNxt = r_pendValid;
    w_pendIdxNxt   = r_pendIdx;
    w_actIdxNxt    = r_actIdx;
    w_blankNxt     = r_blank;
    w_mapRstNxt    = r_mapRst;
    w_busyNxt      = r_busy;
    w_doneNxt      = 1'b0;
    w_cycNxt       = (r_cyc == CNT_MAX) ? r_cyc : r_cyc + CNT_W'(1);
    w_riseNxt      = r_rise;

    unique case (r_state)
      ST_IDLE: begin
        if (r_pendValid) begin
          w_pendValidNxt = 1'b0;
          if (r_pendIdx == r_actIdx) begin
            w_doneNxt = 1'b1;
          end else begin
            w_stateNxt = ST_DRAIN;
            w_busyNxt  = 1'b1;
            w_cycNxt   = '0;
          end
        end
      end

      ST_DRAIN: begin
        if (!w_m2S || (r_cyc == TMO_LAST)) begin
          w_stateNxt  = ST_RESET;
          w_blankNxt  = 1'b1;
          w_mapRstNxt = 1'b1;
          w_actIdxNxt = r_pendIdx;
          w_cycNxt    = '0;
        end
      end

      ST_RESET: begin
        if (r_cyc == RST_LAST) begin
          w_stateNxt  = ST_SETTLE;
          w_mapRstNxt = 1'b0;
          w_cycNxt    = '0;
          w_riseNxt   = '0;
        end
      end

      ST_SETTLE: begin
        if (w_m2Rise) begin
          w_riseNxt = r_rise + RISE_W'(1);
        end
        if ((w_m2Rise && (r_rise == M2_LAST)) || (r_cyc == TMO_LAST)) begin
          w_stateNxt = ST_IDLE;
          w_blankNxt = 1'b0;
          w_busyNxt  = 1'b0;
          w_doneNxt  = 1'b1;
          w_cycNxt   = '0;
        end
      end

      default: begin
        w_stateNxt = ST_IDLE;
      end
    endcase

    // A fresh request always overrides whatever the sequencer did to pending.
    if (bus.req_stb) begin
      w_pendValidNxt = 1'b1;
      w_pendIdxNxt   = bus.req_idx;
    end
  end

  assign bus.act_idx   = r_actIdx;
  assign bus.out_blank = r_blank;
  assign bus.map_rst   = r_mapRst;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_map_sel_ctrl.sv
// Directed bench for map_sel_ctrl: boot state, normal switch, timeouts,
// ignored requests, back-to-back requests, mid-sequence reset, and the index invariant.
module tb_map_sel_ctrl;
  import map_sel_ctrl_pkg::*;

  localparam int IDX_W = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic m2    = 1'b0;

  map_sel_ctrl_if #(.IDX_W(IDX_W)) bus ();

  map_sel_ctrl #(
    .IDX_W     (IDX_W),
    .BOOT_IDX  (0),
    .RST_CYC   (16),
    .SETTLE_M2 (2),
    .TMO_CYC   (4096)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_m2    (m2),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checksRun    = 0;
  int checksPassed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksRun++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Raise a one-cycle request strobe; returns at the negedge after it was taken.
  task automatic applyStimulus(input logic [IDX_W-1:0] idx);
    bus.req_stb = 1'b1;
    bus.req_idx = idx;
    @(negedge clk);
    bus.req_stb = 1'b0;
  endtask

  task automatic waitMapRst(input logic level, input string tag);
    int n;
    n = 0;
    while (bus.map_rst !== level && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) checkOutput(tag, 32'(bus.map_rst), 32'(level));
  endtask

  task automatic countMapRstHigh(output int n);
    n = 0;
    while (bus.map_rst === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Toggle M2 (3 high, 3 low) until done; returns at the negedge showing done.
  task automatic pulseUntilDone(output int pulses);
    pulses = 0;
    for (int p = 1; p <= 20 && pulses == 0; p++) begin
      m2 = 1'b1;
      for (int k = 0; k < 3 && pulses == 0; k++) begin
        @(negedge clk);
        if (bus.done) pulses = p;
      end
      if (pulses == 0) begin
        m2 = 1'b0;
        for (int k = 0; k < 3 && pulses == 0; k++) begin
          @(negedge clk);
          if (bus.done) pulses = p;
        end
      end
    end
  endtask

  // act_idx may only move while the hub is blanked and mappers are in reset.
  logic [IDX_W-1:0] prevAct   = '0;
  bit               rstAtEdge = 1'b1;
  bit               watchTwo  = 1'b0;
  bit               sawTwo    = 1'b0;

  always @(posedge clk) rstAtEdge = !rst_n;

  always @(negedge clk) begin
    if (!rstAtEdge && bus.act_idx !== prevAct)
      checkOutput("invariant blank/rst on idx change",
                  {30'd0, bus.map_rst, bus.out_blank}, 32'd3);
    if (watchTwo && bus.act_idx == IDX_W'(2)) sawTwo = 1'b1;
    prevAct = bus.act_idx;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int pulses;
    bus.req_stb = 1'b0;
    bus.req_idx = '0;

    // Boot state
    repeat (3) @(negedge clk);
    checkOutput("reset act_idx", 32'(bus.act_idx), 32'd0);
    checkOutput("reset outputs", {27'd0, bus.out_blank, bus.map_rst, bus.busy, bus.done, 1'b0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle after reset", {28'd0, bus.out_blank, bus.map_rst, bus.busy, bus.done}, 32'd0);

    // Normal switch to index 4 with M2 low
    applyStimulus(IDX_W'(4));
    checkOutput("t2 busy one cycle after strobe", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("t2 busy two cycles after strobe", 32'(bus.busy), 32'd1);
    checkOutput("t2 map_rst during drain", 32'(bus.map_rst), 32'd0);
    @(negedge clk);
    checkOutput("t2 map_rst/blank rise together", {30'd0, bus.map_rst, bus.out_blank}, 32'd3);
    checkOutput("t2 act_idx loaded", 32'(bus.act_idx), 32'd4);
    countMapRstHigh(n);
    checkOutput("t2 map_rst high cycles", 32'(n), 32'd16);
    checkOutput("t2 blank held in settle", 32'(bus.out_blank), 32'd1);
    pulseUntilDone(pulses);
    checkOutput("t2 m2 rises before done", 32'(pulses), 32'd2);
    checkOutput("t2 busy/blank fall with done", {30'd0, bus.busy, bus.out_blank}, 32'd0);
    checkOutput("t2 final act_idx", 32'(bus.act_idx), 32'd4);
    @(negedge clk);
    checkOutput("t2 done is one cycle", 32'(bus.done), 32'd0);

    // Request for the already-active index is acknowledged and ignored
    m2 = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(IDX_W'(4));
    checkOutput("t3 done not yet", 32'(bus.done), 32'd0);
    @(negedge clk);
    checkOutput("t3 done pulse", 32'(bus.done), 32'd1);
    checkOutput("t3 busy stays low", 32'(bus.busy), 32'd0);
    @(negedge clk);
    checkOutput("t3 no sequence", {29'd0, bus.done, bus.busy, bus.map_rst}, 32'd0);

    // M2 stuck high: drain and settle both end on the timeout
    m2 = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(IDX_W'(7));
    @(negedge clk);
    checkOutput("t4 busy", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.busy && !bus.map_rst && n < 5000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t4 drain timeout cycles", 32'(n), 32'd4096);
    checkOutput("t4 act_idx after drain", 32'(bus.act_idx), 32'd7);
    countMapRstHigh(n);
    checkOutput("t4 map_rst high cycles", 32'(n), 32'd16);
    n = 0;
    while (!bus.done && n < 5000) begin
      n++;
      @(negedge clk);
    end
    checkOutput("t4 settle timeout cycles", 32'(n), 32'd4096);
    checkOutput("t4 done busy blank", {29'd0, bus.done, bus.busy, bus.out_blank}, 32'd4);
    checkOutput("t4 final act_idx", 32'(bus.act_idx), 32'd7);

    // Two requests during RESET: only the latest (3) follows the first switch
    m2 = 1'b0;
    watchTwo = 1'b1;
    repeat (3) @(negedge clk);
    applyStimulus(IDX_W'(5));
    waitMapRst(1'b1, "t5 first map_rst rise");
    bus.req_stb = 1'b1;
    bus.req_idx = IDX_W'(2);
    @(negedge clk);
    bus.req_idx = IDX_W'(3);
    @(negedge clk);
    bus.req_stb = 1'b0;
    waitMapRst(1'b0, "t5 first map_rst fall");
    pulseUntilDone(pulses);
    checkOutput("t5 first switch done", 32'(bus.done), 32'd1);
    checkOutput("t5 first act_idx", 32'(bus.act_idx), 32'd5);
    m2 = 1'b0;
    @(negedge clk);
    checkOutput("t5 second busy after done", 32'(bus.busy), 32'd1);
    waitMapRst(1'b1, "t5 second map_rst rise");
    checkOutput("t5 second act_idx", 32'(bus.act_idx), 32'd3);
    waitMapRst(1'b0, "t5 second map_rst fall");
    pulseUntilDone(pulses);
    checkOutput("t5 second switch done", 32'(bus.done), 32'd1);
    checkOutput("t5 index 2 never applied", 32'(sawTwo), 32'd0);
    watchTwo = 1'b0;

    // Reset in the middle of RESET aborts back to the boot index
    m2 = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(IDX_W'(9));
    waitMapRst(1'b1, "t6 map_rst rise");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("t6 act_idx after abort", 32'(bus.act_idx), 32'd0);
    checkOutput("t6 outputs after abort", {28'd0, bus.out_blank, bus.map_rst, bus.busy, bus.done}, 32'd0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.busy) n++;
    end
    checkOutput("t6 no pending after abort", 32'(n), 32'd0);

    // Random requests and M2 activity; the monitor watches the invariant
    for (int i = 0; i < 400; i++) begin
      bus.req_stb = ($urandom_range(0, 19) == 0);
      bus.req_idx = IDX_W'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) m2 = ~m2;
      @(negedge clk);
    end
    bus.req_stb = 1'b0;
    n = 0;
    for (int i = 0; i < 20000 && n < 8; i++) begin
      if ((i % 3) == 0) m2 = ~m2;
      @(negedge clk);
      n = bus.busy ? 0 : n + 1;
    end
    checkOutput("random phase quiesces", 32'(n), 32'd8);

    $display("%0d/%0d checks passed", checksPassed, checksRun);
    $finish;
  end

endmodule
